packet_bridge: RTL and testbench

PACKET_BRIDGE -- requirements
Module: packet_bridge

---
 rtl/pkt_pkg.sv | 25 ++
 rtl/packet_bridge_mem.sv | 32 +++
 rtl/packet_bridge.sv | 139 +++++++++++++
 tb/tb_packet_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared packet types for the bridge and the producer/consumer blocks around it.
package pkt_pkg;

   localparam int PKT_DATA_W = 8;

   // Upstream side: producer offers data with a valid qualifier.
   typedef struct packed {
      logic [PKT_DATA_W-1:0] data;
      logic                  valid;
   } packet_a_t;

   // Downstream side: ready means an entry is available at the head.
   typedef struct packed {
      logic [PKT_DATA_W-1:0] data;
      logic                  ready;
   } packet_b_t;

   // Coarse occupancy of the bridge FIFO.
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_e;

endpackage

// File: rtl/packet_bridge_mem.sv
// Storage array for the packet bridge: one synchronous write port and one
// asynchronous read port. Contents are not reset; the bridge never exposes
// an entry that was not written since the last reset or flush.
module packet_bridge_mem
   import pkt_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = PKT_DATA_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write the accepted packet into the slot addressed by the write pointer.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Head entry is read combinationally from the registered read pointer.
   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/packet_bridge.sv
// Packet bridge: a DEPTH-entry FIFO between a valid-qualified producer and an
// ack-driven consumer, with synchronous flush and a saturating counter of
// packets refused because the FIFO was full.
module packet_bridge
   import pkt_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  packet_a_t                    pkt_in,
   output logic                         in_ready,
   output packet_b_t                    pkt_out,
   input  logic                         out_ack,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [DROP_W-1:0]            drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   occ_state_e        occ_q;

   logic                  push;
   logic                  pop;
   logic                  out_ready;
   logic [PKT_DATA_W-1:0] head_data;

   packet_bridge_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (PKT_DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (pkt_in.data),
      .raddr (rd_ptr_q),
      .rdata (head_data)
   );

   // Handshake flags and output packet come only from registered state, so
   // out_ack never reaches in_ready and a push is visible one cycle later.
   always_comb begin
      in_ready     = (occ_q != OCC_FULL);
      out_ready    = (occ_q != OCC_EMPTY);
      pkt_out      = '0;
      pkt_out.ready = out_ready;
      pkt_out.data  = out_ready ? head_data : '0;
      count        = count_q;
      drop_cnt     = drop_cnt_q;
      push         = pkt_in.valid && in_ready && !flush;
      pop          = out_ack && out_ready && !flush;
   end

   // Next-state for pointers, occupancy and the refused-packet counter.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
      // A refusal is counted whenever the FIFO was full, flush or not.
      if (pkt_in.valid && !in_ready && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
   end

   // Datapath state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Occupancy FSM: moves one step per push-only or pop-only cycle, or
   // straight to EMPTY on flush; simultaneous push and pop hold the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= OCC_EMPTY;
      end else if (flush) begin
         occ_q <= OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (push) begin
                  occ_q <= OCC_PARTIAL;
               end
            end
            OCC_PARTIAL: begin
               if (push && !pop && (count_q == CNT_W'(DEPTH-1))) begin
                  occ_q <= OCC_FULL;
               end else if (pop && !push && (count_q == CNT_W'(1))) begin
                  occ_q <= OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (pop) begin
                  occ_q <= OCC_PARTIAL;
               end
            end
            default: begin
               occ_q <= OCC_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_packet_bridge.sv
// Bench for packet_bridge: a directed vector table for the main sequence,
// plus hand-written sequences for pointer wrap, drop saturation and a
// mid-stream reset. A second instance with DROP_W=2 shares the stimulus.
module tb_packet_bridge;
   import pkt_pkg::*;

   logic       clk;
   logic       rst_n;
   packet_a_t  pkt_in;
   logic       out_ack;
   logic       flush;

   logic       in_ready,  in_ready2;
   packet_b_t  pkt_out,   pkt_out2;
   logic [2:0] count,     count2;
   logic [7:0] drop_cnt;
   logic [1:0] drop_cnt2;

   int checks;
   int errors;

   packet_bridge #(.DEPTH(4), .DROP_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pkt_in   (pkt_in),
      .in_ready (in_ready),
      .pkt_out  (pkt_out),
      .out_ack  (out_ack),
      .flush    (flush),
      .count    (count),
      .drop_cnt (drop_cnt)
   );

   packet_bridge #(.DEPTH(4), .DROP_W(2)) dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .pkt_in   (pkt_in),
      .in_ready (in_ready2),
      .pkt_out  (pkt_out2),
      .out_ack  (out_ack),
      .flush    (flush),
      .count    (count2),
      .drop_cnt (drop_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [7:0] din;
      logic       ack;
      logic       flsh;
      logic       e_in_rdy;
      logic       e_rdy;
      logic [7:0] e_data;
      logic [2:0] e_cnt;
      logic [7:0] e_drop;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic a, input logic f);
      pkt_in.valid = v;
      pkt_in.data  = d;
      out_ack      = a;
      flush        = f;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " in_ready"},  32'(in_ready),      32'd1);
      chk({tag, " ready"},     32'(pkt_out.ready), 32'd0);
      chk({tag, " data"},      32'(pkt_out.data),  32'd0);
      chk({tag, " count"},     32'(count),         32'd0);
      chk({tag, " drop"},      32'(drop_cnt),      32'd0);
      chk({tag, " drop2"},     32'(drop_cnt2),     32'd0);
      chk({tag, " ready2"},    32'(pkt_out2.ready), 32'd0);
   endtask

   logic [7:0] mq [$];
   logic [7:0] exp_head;

   initial begin
      checks = 0;
      errors = 0;

      //           valid din    ack  flush in_rdy rdy data  cnt drop
      tbl[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 3'd1, 8'd0};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};
      tbl[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1, 8'd0};
      tbl[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2, 8'd0};
      tbl[5]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3, 8'd0};
      tbl[6]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 8'd0};
      tbl[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 8'd1};
      tbl[8]  = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 3'd3, 8'd2};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 3'd2, 8'd2};
      tbl[10] = '{1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2, 8'd2};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 3'd1, 8'd2};
      tbl[12] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 3'd2, 8'd2};
      tbl[13] = '{1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 3'd3, 8'd2};
      tbl[14] = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 8'd2};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'd2};
      tbl[16] = '{1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 1'b1, 8'h50, 3'd1, 8'd2};
      tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'd2};
      tbl[18] = '{1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61, 3'd1, 8'd2};
      tbl[19] = '{1'b1, 8'h62, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61, 3'd2, 8'd2};
      tbl[20] = '{1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61, 3'd3, 8'd2};
      tbl[21] = '{1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1, 8'h61, 3'd4, 8'd2};
      tbl[22] = '{1'b1, 8'h65, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 8'd3};
      tbl[23] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 8'd3};

      // Power-on reset.
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #12;
      chk_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Main directed sequence.
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].valid, tbl[i].din, tbl[i].ack, tbl[i].flsh);
         tick();
         chk($sformatf("row%0d in_ready", i), 32'(in_ready),      32'(tbl[i].e_in_rdy));
         chk($sformatf("row%0d ready", i),    32'(pkt_out.ready), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d data", i),     32'(pkt_out.data),  32'(tbl[i].e_data));
         chk($sformatf("row%0d count", i),    32'(count),         32'(tbl[i].e_cnt));
         chk($sformatf("row%0d drop", i),     32'(drop_cnt),      32'(tbl[i].e_drop));
         chk($sformatf("row%0d drop2", i),    32'(drop_cnt2),     32'(tbl[i].e_drop[1:0]));
         $display("row%0d v=%0d d=%h ack=%0d fl=%0d -> cnt=%0d data=%h drop=%0d",
                  i, tbl[i].valid, tbl[i].din, tbl[i].ack, tbl[i].flsh,
                  count, pkt_out.data, drop_cnt);
      end

      // Pointer wrap: 10 pushes streamed through, popping once two are queued.
      mq.delete();
      for (int i = 0; i < 12; i++) begin
         logic v;
         logic a;
         logic [7:0] d;
         v = (i < 10);
         a = (i >= 2);
         d = 8'hC0 + 8'(i);
         drive(v, d, a, 1'b0);
         if (a && mq.size() > 0) void'(mq.pop_front());
         if (v && mq.size() < 4) mq.push_back(d);
         tick();
         exp_head = (mq.size() > 0) ? mq[0] : 8'h00;
         chk($sformatf("wrap%0d data", i),  32'(pkt_out.data), 32'(exp_head));
         chk($sformatf("wrap%0d count", i), 32'(count),        32'(mq.size()));
         $display("wrap%0d push=%0d ack=%0d -> cnt=%0d head=%h", i, v, a, count, pkt_out.data);
      end

      // Fill, then offer five packets while full: DROP_W=2 saturates at 3.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
         tick();
      end
      chk("fill count", 32'(count), 32'd4);
      chk("fill head", 32'(pkt_out.data), 32'hD0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
         tick();
         chk($sformatf("sat%0d drop2", i), 32'(drop_cnt2), 32'd3);
         $display("sat%0d drop=%0d drop2=%0d", i, drop_cnt, drop_cnt2);
      end
      chk("sat drop8", 32'(drop_cnt), 32'd8);
      chk("sat count", 32'(count), 32'd4);

      // Asynchronous reset pulse mid-stream, away from any clock edge.
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_state("midrst");
      $display("midrst cnt=%0d ready=%0d drop=%0d", count, pkt_out.ready, drop_cnt);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hAB, 1'b0, 1'b0);
      tick();
      chk("postrst count", 32'(count), 32'd1);
      chk("postrst data", 32'(pkt_out.data), 32'hAB);
      chk("postrst ready", 32'(pkt_out.ready), 32'd1);
      chk("postrst drop", 32'(drop_cnt), 32'd0);
      $display("postrst cnt=%0d data=%h", count, pkt_out.data);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
